ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter FIXED_PRIO, default 0: 1 = port 0 always wins ties; 0 = round-robin ties.
REQ-003 SHALL have parameter MAX_WAIT, default 8, range 2..255: consecutive denied cycles before the starvation override applies.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have, per port N in {0,1}, the following inputs: pN_req (1), pN_wen (1), pN_flag (4, byte enables), pN_addr (AW), pN_wdata (32), pN_lock (1, hold ownership after this access).
REQ-007 SHALL have, per port N, the following outputs: pN_gnt (1), pN_rvalid (1), pN_rdata (32).
REQ-008 SHALL have the memory-side outputs mem_cen (1), mem_wen (1), mem_flag (4), mem_addr (AW) and mem_wdata (32).
REQ-009 SHALL have the memory-side input mem_rdata (32), which is valid one cycle after a read command.

Function
REQ-010 Arbitration SHALL use a state machine with states IDLE, OWN0 and OWN1.
REQ-011 In IDLE, a lone requester SHALL be granted.
REQ-012 In IDLE, a tie SHALL go to port 0 when FIXED_PRIO=1; otherwise it SHALL go to the port not granted most recently (last_gnt register).
REQ-013 In OWNn, only port n SHALL be grantable, except under the override of REQ-019.
REQ-014 Grant SHALL be combinational in the request cycle.
- pN_gnt = pN_req AND selected.
- mem_cen = OR of the grants.
- mem_wen, mem_flag, mem_addr and mem_wdata SHALL mirror the granted port.
REQ-015 With no grant, mem_cen SHALL be 0, and mem_wen, mem_flag, mem_addr and mem_wdata SHALL be 0.
REQ-016 At most one pN_gnt SHALL be high in any cycle.
REQ-017 Lock transitions SHALL be:
- a granted access with pN_lock=1 moves to, or stays in, OWNN;
- a granted access with pN_lock=0 returns to IDLE;
- in OWNN with pN_req=0, the state holds.
REQ-018 Each port SHALL have a wait counter (8 bits).
- Increment when pN_req=1 and pN_gnt=0.
- Clear on grant or when req=0.
- Saturate at MAX_WAIT.
REQ-019 Starvation override: when wait counter N = MAX_WAIT and port N requests, port N SHALL be granted that cycle regardless of priority or OWNm.
- Grant terminates OWNm: next state = IDLE, or OWNN if pN_lock=1.
- If both counters saturate together, port 0 wins.
REQ-020 last_gnt SHALL update to the granted port index on every grant.
REQ-021 Read return: a granted read (wen=0) in cycle t SHALL give pN_rvalid=1 for exactly cycle t+1, with pN_rdata=mem_rdata.
REQ-022 When pN_rvalid=0, pN_rdata SHALL be 0.
REQ-023 Writes SHALL never produce rvalid.
REQ-024 Back-to-back reads by alternating ports SHALL each return data in the correct cycle, with no bubble.
REQ-025 Write byte enables SHALL pass through unmodified; flag=4'b0000 with wen=1 SHALL still be issued as a command.

Reset
REQ-026 While rst=0, the following SHALL hold: state=IDLE; last_gnt=1 (first tie goes to port 0 under round-robin); both wait counters=0; rvalid pipeline cleared.
REQ-027 While rst=0, all grants and all mem_* outputs SHALL be 0, and both pN_rvalid and both pN_rdata SHALL be 0.
REQ-028 Reset asserted mid-lock or with a read in flight SHALL drop the lock and the pending rvalid; no rvalid SHALL appear after reset release.

Verification
REQ-029 Scenario: FIXED_PRIO=0, both ports read continuously (p0_addr=0x40000000, p1_addr=0x40000004) -> grants alternate 0,1,0,1...; each rvalid arrives one cycle later carrying the matching mem_rdata.
REQ-030 Scenario: port 0 writes with lock=1 for 3 cycles, then lock=0, while port 1 requests throughout -> port 1 is denied for 4 cycles and granted in cycle 5; wait counter 1 peaks at 4.
REQ-031 Scenario: MAX_WAIT=4, port 0 holds lock indefinitely, port 1 requests -> port 1 is granted in the 5th request cycle, port 0 is denied that cycle, and the state goes to IDLE.
REQ-032 Scenario: FIXED_PRIO=1, both ports request reads continuously with MAX_WAIT=8 -> port 0 wins 8 cycles, port 1 is granted on the 9th, then port 0 resumes.
REQ-033 Scenario: port 1 write with flag=4'b0101 and wdata=0xAABBCCDD -> the same cycle shows mem_cen=1, mem_wen=1, mem_flag=4'b0101, mem_wdata=0xAABBCCDD; no rvalid follows.
REQ-034 Scenario: rst driven low one cycle after a granted locked read -> no rvalid; after release, state=IDLE and a tie grants port 0.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-ported RAM.
// Lock ownership, round-robin/fixed ties, starvation override, read return.
module ram_arbiter #(
   parameter int AW         = 32,
   parameter int FIXED_PRIO = 0,
   parameter int MAX_WAIT   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_req,
   input  logic          p0_wen,
   input  logic [3:0]    p0_flag,
   input  logic [AW-1:0] p0_addr,
   input  logic [31:0]   p0_wdata,
   input  logic          p0_lock,
   input  logic          p1_req,
   input  logic          p1_wen,
   input  logic [3:0]    p1_flag,
   input  logic [AW-1:0] p1_addr,
   input  logic [31:0]   p1_wdata,
   input  logic          p1_lock,
   output logic          p0_gnt,
   output logic          p0_rvalid,
   output logic [31:0]   p0_rdata,
   output logic          p1_gnt,
   output logic          p1_rvalid,
   output logic [31:0]   p1_rdata,
   output logic          mem_cen,
   output logic          mem_wen,
   output logic [3:0]    mem_flag,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [7:0] WMAX = 8'(MAX_WAIT);

   state_t     state_q, state_d;
   logic       last_gnt_q, last_gnt_d;
   logic [7:0] wait0_q, wait0_d;
   logic [7:0] wait1_q, wait1_d;
   logic       rv0_q, rv0_d;
   logic       rv1_q, rv1_d;

   logic req0, req1;
   logic starve0, starve1;
   logic sel0, sel1;

   // Requests are masked while reset is held so nothing reaches memory.
   assign req0    = p0_req & rst;
   assign req1    = p1_req & rst;
   assign starve0 = req0 && (wait0_q == WMAX);
   assign starve1 = req1 && (wait1_q == WMAX);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a grant decides ownership, otherwise hold.
   always_comb begin
      state_d = state_q;
      if (p0_gnt) begin
         state_d = p0_lock ? OWN0 : IDLE;
      end else if (p1_gnt) begin
         state_d = p1_lock ? OWN1 : IDLE;
      end
   end

   // Grant select: starvation first, then owner, then tie-break.
   always_comb begin
      sel0 = 1'b0;
      sel1 = 1'b0;
      if (starve0) begin
         sel0 = 1'b1;
      end else if (starve1) begin
         sel1 = 1'b1;
      end else begin
         case (state_q)
            OWN0: sel0 = 1'b1;
            OWN1: sel1 = 1'b1;
            default: begin
               if (req0 && req1) begin
                  if (FIXED_PRIO != 0 || last_gnt_q) sel0 = 1'b1;
                  else                               sel1 = 1'b1;
               end else begin
                  sel0 = req0;
                  sel1 = req1;
               end
            end
         endcase
      end
   end

   assign p0_gnt  = req0 & sel0;
   assign p1_gnt  = req1 & sel1;
   assign mem_cen = p0_gnt | p1_gnt;

   // Memory command mirrors the granted port, zero when idle.
   always_comb begin
      mem_wen   = 1'b0;
      mem_flag  = 4'b0000;
      mem_addr  = '0;
      mem_wdata = '0;
      if (p0_gnt) begin
         mem_wen   = p0_wen;
         mem_flag  = p0_flag;
         mem_addr  = p0_addr;
         mem_wdata = p0_wdata;
      end else if (p1_gnt) begin
         mem_wen   = p1_wen;
         mem_flag  = p1_flag;
         mem_addr  = p1_addr;
         mem_wdata = p1_wdata;
      end
   end

   // Wait counters, last-grant history and read-return pipeline.
   always_comb begin
      last_gnt_d = last_gnt_q;
      if (p0_gnt)      last_gnt_d = 1'b0;
      else if (p1_gnt) last_gnt_d = 1'b1;
      wait0_d = 8'd0;
      if (req0 && !p0_gnt)
         wait0_d = (wait0_q == WMAX) ? wait0_q : wait0_q + 8'd1;
      wait1_d = 8'd0;
      if (req1 && !p1_gnt)
         wait1_d = (wait1_q == WMAX) ? wait1_q : wait1_q + 8'd1;
      rv0_d = p0_gnt & ~p0_wen;
      rv1_d = p1_gnt & ~p1_wen;
   end

   // Datapath flops; last_gnt resets to 1 so the first tie goes to port 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_gnt_q <= 1'b1;
         wait0_q    <= 8'd0;
         wait1_q    <= 8'd0;
         rv0_q      <= 1'b0;
         rv1_q      <= 1'b0;
      end else begin
         last_gnt_q <= last_gnt_d;
         wait0_q    <= wait0_d;
         wait1_q    <= wait1_d;
         rv0_q      <= rv0_d;
         rv1_q      <= rv1_d;
      end
   end

   assign p0_rvalid = rv0_q;
   assign p1_rvalid = rv1_q;
   assign p0_rdata  = rv0_q ? mem_rdata : 32'd0;
   assign p1_rdata  = rv1_q ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: three instances share the stimulus
// (round-robin/8, fixed-priority/8, round-robin/4) with hand-set grants.
module tb_ram_arbiter;

   localparam int ND = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_wen, p0_lock;
   logic [3:0]  p0_flag;
   logic [31:0] p0_addr, p0_wdata;
   logic        p1_req, p1_wen, p1_lock;
   logic [3:0]  p1_flag;
   logic [31:0] p1_addr, p1_wdata;
   logic [31:0] mem_rdata;

   logic [ND-1:0] g0_w, g1_w, rv0_w, rv1_w, cen_w, wen_w;
   logic [3:0]    flag_w  [ND];
   logic [31:0]   addr_w  [ND];
   logic [31:0]   wdata_w [ND];
   logic [31:0]   rd0_w   [ND];
   logic [31:0]   rd1_w   [ND];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      ram_arbiter #(
         .AW(32),
         .FIXED_PRIO(g == 1 ? 1 : 0),
         .MAX_WAIT(g == 2 ? 4 : 8)
      ) u_dut (
         .clk(clk), .rst(rst),
         .p0_req(p0_req), .p0_wen(p0_wen), .p0_flag(p0_flag),
         .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
         .p1_req(p1_req), .p1_wen(p1_wen), .p1_flag(p1_flag),
         .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_lock(p1_lock),
         .p0_gnt(g0_w[g]), .p0_rvalid(rv0_w[g]), .p0_rdata(rd0_w[g]),
         .p1_gnt(g1_w[g]), .p1_rvalid(rv1_w[g]), .p1_rdata(rd1_w[g]),
         .mem_cen(cen_w[g]), .mem_wen(wen_w[g]), .mem_flag(flag_w[g]),
         .mem_addr(addr_w[g]), .mem_wdata(wdata_w[g]),
         .mem_rdata(mem_rdata)
      );
   end

   typedef struct {
      int          cyc;
      int          dut;
      int          kind;
      logic [31:0] exp;
   } item_t;

   item_t sb[$];
   item_t keep[$];
   int    n_vec = 0;
   int    n_bad = 0;
   string kname [7] = '{"gnt", "rvalid", "rdata0", "rdata1",
                        "memctl", "memaddr", "memwdata"};

   function automatic logic [31:0] pat(int c);
      return 32'hD000_0000 ^ 32'(c);
   endfunction

   function automatic logic [31:0] actual(int d, int k);
      case (k)
         0: return {30'b0, g1_w[d], g0_w[d]};
         1: return {30'b0, rv1_w[d], rv0_w[d]};
         2: return rd0_w[d];
         3: return rd1_w[d];
         4: return {26'b0, cen_w[d], wen_w[d], flag_w[d]};
         5: return addr_w[d];
         default: return wdata_w[d];
      endcase
   endfunction

   task automatic push(int c, int d, int k, logic [31:0] v);
      item_t it;
      it = '{cyc: c, dut: d, kind: k, exp: v};
      sb.push_back(it);
   endtask

   // Expected grant g for instance d this cycle, plus the read return next cycle.
   task automatic exp_g(int d, logic [1:0] g, bit rst_next = 1'b0);
      logic [31:0] ctl, ad, wd;
      logic [1:0]  rv;
      ctl = 32'd0;
      ad  = 32'd0;
      wd  = 32'd0;
      if (g[0]) begin
         ctl = {26'b0, 1'b1, p0_wen, p0_flag};
         ad  = p0_addr;
         wd  = p0_wdata;
      end else if (g[1]) begin
         ctl = {26'b0, 1'b1, p1_wen, p1_flag};
         ad  = p1_addr;
         wd  = p1_wdata;
      end
      rv = rst_next ? 2'b00 : (g & ~{p1_wen, p0_wen});
      push(cyc, d, 0, {30'b0, g});
      push(cyc, d, 4, ctl);
      push(cyc, d, 5, ad);
      push(cyc, d, 6, wd);
      push(cyc + 1, d, 1, {30'b0, rv});
      push(cyc + 1, d, 2, rv[0] ? pat(cyc + 1) : 32'd0);
      push(cyc + 1, d, 3, rv[1] ? pat(cyc + 1) : 32'd0);
   endtask

   task automatic exp3(logic [1:0] a, logic [1:0] b, logic [1:0] c,
                       bit rn = 1'b0);
      exp_g(0, a, rn);
      exp_g(1, b, rn);
      exp_g(2, c, rn);
   endtask

   task automatic check(item_t it);
      logic [31:0] a;
      a = actual(it.dut, it.kind);
      n_vec++;
      if (a !== it.exp) begin
         n_bad++;
         $display("FAIL %s dut%0d cyc%0d: got %h want %h",
                  kname[it.kind], it.dut, it.cyc, a, it.exp);
      end
   endtask

   // Monitor: compare every entry due this cycle, flag any overdue one.
   always @(negedge clk) begin
      keep = {};
      foreach (sb[i]) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i]);
         end else if (sb[i].cyc < cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL overdue %s dut%0d cyc%0d: got none want %h",
                     kname[sb[i].kind], sb[i].dut, sb[i].cyc, sb[i].exp);
         end else begin
            keep.push_back(sb[i]);
         end
      end
      sb = keep;
   end

   task automatic step();
      @(posedge clk);
      #1;
      mem_rdata = pat(cyc);
   endtask

   task automatic drv0(bit r, bit w, bit l, logic [3:0] f,
                       logic [31:0] a, logic [31:0] d);
      p0_req = r; p0_wen = w; p0_lock = l;
      p0_flag = f; p0_addr = a; p0_wdata = d;
   endtask

   task automatic drv1(bit r, bit w, bit l, logic [3:0] f,
                       logic [31:0] a, logic [31:0] d);
      p1_req = r; p1_wen = w; p1_lock = l;
      p1_flag = f; p1_addr = a; p1_wdata = d;
   endtask

   task automatic idle();
      drv0(0, 0, 0, 4'h0, 32'd0, 32'd0);
      drv1(0, 0, 0, 4'h0, 32'd0, 32'd0);
   endtask

   // Reset with both ports requesting locked reads: nothing may leak out.
   task automatic do_reset();
      step(); idle(); exp3(2'b00, 2'b00, 2'b00);
      step(); rst = 1'b0;
      drv0(1, 0, 1, 4'hF, 32'h10, 32'd0);
      drv1(1, 0, 1, 4'hF, 32'h14, 32'd0);
      exp3(2'b00, 2'b00, 2'b00);
      step(); exp3(2'b00, 2'b00, 2'b00);
      step(); rst = 1'b1; idle(); exp3(2'b00, 2'b00, 2'b00);
   endtask

   initial begin
      rst = 1'b0;
      idle();
      mem_rdata = 32'd0;

      do_reset();

      // Both ports read continuously.
      for (int i = 0; i < 6; i++) begin
         step();
         drv0(1, 0, 0, 4'hF, 32'h4000_0000, 32'd0);
         drv1(1, 0, 0, 4'hF, 32'h4000_0004, 32'd0);
         exp3(i % 2 ? 2'b10 : 2'b01, 2'b01, i % 2 ? 2'b10 : 2'b01);
      end

      // Port 0 locked writes for 3 cycles, unlocked on the 4th and 5th.
      do_reset();
      for (int c = 1; c <= 5; c++) begin
         step();
         drv0(1, 1, c <= 3, 4'hF, 32'h100 + 32'(c), 32'h1111_0000 + 32'(c));
         drv1(1, 0, 0, 4'hF, 32'h200, 32'd0);
         if (c <= 4) exp3(2'b01, 2'b01, 2'b01);
         else        exp3(2'b10, 2'b01, 2'b10);
      end

      // Port 0 holds a lock; port 1 breaks in by starvation.
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         step();
         drv0(c < 10, 1, 1, 4'h3, 32'h300, 32'hCAFE_0000 + 32'(c));
         drv1(1, 0, 0, 4'hF, 32'h304, 32'd0);
         exp3(c <= 8 ? 2'b01 : 2'b10,
              c <= 8 ? 2'b01 : 2'b10,
              (c == 5 || c == 10) ? 2'b10 : 2'b01);
      end

      // Continuous tie: fixed priority lets port 1 in on the 9th cycle.
      do_reset();
      for (int c = 1; c <= 10; c++) begin
         step();
         drv0(1, 0, 0, 4'hF, 32'h500, 32'd0);
         drv1(1, 0, 0, 4'hF, 32'h504, 32'd0);
         exp3(c % 2 ? 2'b01 : 2'b10,
              c == 9 ? 2'b10 : 2'b01,
              c % 2 ? 2'b01 : 2'b10);
      end

      // Byte-enable pass-through, including an all-zero mask write.
      do_reset();
      step(); idle();
      drv1(1, 1, 0, 4'b0101, 32'h600, 32'hAABB_CCDD);
      exp3(2'b10, 2'b10, 2'b10);
      step(); idle();
      drv0(1, 1, 0, 4'b0000, 32'h604, 32'h1234_5678);
      exp3(2'b01, 2'b01, 2'b01);

      // Reset right after a granted locked read.
      do_reset();
      step(); idle();
      drv0(1, 0, 1, 4'hF, 32'h700, 32'd0);
      exp3(2'b01, 2'b01, 2'b01, 1'b1);
      step(); rst = 1'b0;
      exp3(2'b00, 2'b00, 2'b00);
      step(); rst = 1'b1;
      drv0(1, 0, 0, 4'hF, 32'h710, 32'd0);
      drv1(1, 0, 0, 4'hF, 32'h714, 32'd0);
      exp3(2'b01, 2'b01, 2'b01);
      step(); idle(); exp3(2'b00, 2'b00, 2'b00);
      step(); exp3(2'b00, 2'b00, 2'b00);

      step();
      step();
      @(negedge clk);
      #1;
      n_vec++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
